// File: rtl/quad_gen.sv
// Quadrature A/B generator driven by direction/step-count move commands.
// Emits one Gray-code edge per programmed period and tracks the resulting position.
module quad_gen #(
    parameter int CNT_W  = 8,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  period,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              quad_A,
    output logic              quad_B,
    output logic [CNT_W-1:0]  position
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_dir;
    logic [STEP_W-1:0] r_rem;
    logic [DIV_W-1:0]  r_timer;
    logic [DIV_W-1:0]  r_reload;
    logic [1:0]        r_phase;
    logic              r_a;
    logic              r_b;
    logic              r_done;
    logic [CNT_W-1:0]  r_pos;

    logic              w_accept;
    logic              w_edge;
    logic              w_done;
    logic [DIV_W-1:0]  w_per_m1;
    logic [1:0]        w_phase_nxt;

    // A period of 0 behaves like 1, so the reload value saturates at 0
    assign w_per_m1    = (period == '0) ? '0 : period - DIV_W'(1);
    assign w_phase_nxt = r_dir ? r_phase + 2'd1 : r_phase - 2'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_edge      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_steps == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end else if (r_timer == '0) begin
                    w_edge = 1'b1;
                    if (r_rem == STEP_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir    <= 1'b0;
            r_rem    <= '0;
            r_timer  <= '0;
            r_reload <= '0;
            r_phase  <= 2'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_done   <= 1'b0;
            r_pos    <= '0;
        end else begin
            r_done <= w_done;
            if (w_accept) begin
                r_dir    <= cmd_dir;
                r_rem    <= cmd_steps;
                r_timer  <= w_per_m1;
                r_reload <= w_per_m1;
            end else if (w_edge) begin
                // Phase map 0:00 1:10 2:11 3:01 -> A = p1^p0, B = p1
                r_phase <= w_phase_nxt;
                r_a     <= w_phase_nxt[1] ^ w_phase_nxt[0];
                r_b     <= w_phase_nxt[1];
                r_pos   <= r_dir ? r_pos + CNT_W'(1) : r_pos - CNT_W'(1);
                r_rem   <= r_rem - STEP_W'(1);
                r_timer <= r_reload;
            end else if (r_state == S_RUN) begin
                r_timer <= r_timer - DIV_W'(1);
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign cmd_ready = ~busy;
    assign done      = r_done;
    assign quad_A    = r_a;
    assign quad_B    = r_b;
    assign position  = r_pos;

endmodule
